// File: rtl/stdc_event_collector.sv
// N-channel TDC event collector: per-channel hold registers, round-robin merge into a shared FIFO,
// Wishbone slave for CPU drain. Optional threshold/overflow interrupt when STDC_COLLECT_IRQ_EN is defined.
module stdc_event_collector #(
   parameter int N_CH = 2,
   parameter int TS_W = 27,
   parameter int AW   = 6
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [N_CH-1:0]      ev_stb_i,
   input  logic [N_CH-1:0]      ev_pol_i,
   input  logic [N_CH*TS_W-1:0] ev_ts_i,
   input  logic [31:0]          wb_adr_i,
   input  logic [31:0]          wb_dat_i,
   output logic [31:0]          wb_dat_o,
   input  logic [3:0]           wb_sel_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   output logic                 wb_ack_o,
   output logic                 irq_o
);

   localparam int          CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_STAT = 2'd1,
      REG_CTRL = 2'd2,
      REG_IRQ  = 2'd3
   } reg_e;

   logic [N_CH-1:0] hold_v;
   logic [31:0]     hold_w [N_CH];
   logic [31:0]     ev_word [N_CH];
   logic [CW-1:0]   rr_ptr;
   logic [CW-1:0]   grant_idx;
   logic [CW-1:0]   cand;
   logic            grant_vld;

   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     level;
   logic            empty, full;

   logic [N_CH-1:0] en, ovf, ovf_set, ovf_clr, drain, load;
   logic [15:0]     thr;
   logic [31:0]     rd_data;
   reg_e            reg_sel;
   logic            acc, wr_acc, rd_acc, flush, push, pop;

   logic unused_ok;
   assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

   // A new access is taken only when ack is low, so every access is two cycles.
   assign reg_sel = reg_e'(wb_adr_i[3:2]);
   assign acc     = wb_cyc_i && wb_stb_i && !wb_ack_o;
   assign wr_acc  = acc && wb_we_i;
   assign rd_acc  = acc && !wb_we_i;
   assign flush   = wr_acc && (reg_sel == REG_CTRL) && wb_dat_i[16];
   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign pop     = rd_acc && (reg_sel == REG_DATA) && !empty;
   assign push    = grant_vld && (!full || pop) && !flush;
   assign ovf_clr = (wr_acc && (reg_sel == REG_STAT)) ? wb_dat_i[16 +: N_CH] : '0;

   // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < N_CH; i++) begin
         cand = CW'((int'(rr_ptr) + i) % N_CH);
         if (!grant_vld && hold_v[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // A hold drained on this edge is free to take a new strobe on the same edge.
   always_comb begin
      drain   = '0;
      load    = '0;
      ovf_set = '0;
      for (int k = 0; k < N_CH; k++) begin
         ev_word[k] = {4'(k), ev_pol_i[k], 27'(ev_ts_i[k*TS_W +: TS_W])};
         drain[k]   = push && (grant_idx == CW'(k));
         load[k]    = ev_stb_i[k] && en[k] && (!hold_v[k] || drain[k]) && !flush;
         ovf_set[k] = ev_stb_i[k] && en[k] && hold_v[k] && !drain[k] && !flush;
      end
   end

   // NOTE: sequential state uses non-blocking assignment only; the later assignment to the same bit wins.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hold_v <= '0;
         for (int k = 0; k < N_CH; k++) hold_w[k] <= '0;
      end else if (flush) begin
         hold_v <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (drain[k]) hold_v[k] <= 1'b0;
            if (load[k]) begin
               hold_v[k] <= 1'b1;
               hold_w[k] <= ev_word[k];
            end
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         rr_ptr <= '0;
      else if (push)
         rr_ptr <= (grant_idx == CW'(N_CH-1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   // NOTE: storage array has no reset; pointers and level define which entries are valid.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr] <= hold_w[grant_idx];
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_DATA: rd_data = empty ? 32'hFFFF_FFFF : mem[rd_ptr];
         REG_STAT: rd_data = {16'(ovf), 16'(level)};
         REG_CTRL: rd_data = {16'h0000, 16'(en)};
         REG_IRQ:  rd_data = {irq_o, 15'h0000, thr};
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         en       <= '0;
         ovf      <= '0;
      end else begin
         wb_ack_o <= acc;
         if (acc) wb_dat_o <= rd_data;
         if (wr_acc && (reg_sel == REG_CTRL)) en <= wb_dat_i[N_CH-1:0];
         // A loss in the same cycle as its clear stays visible.
         ovf <= (ovf & ~ovf_clr) | ovf_set;
      end
   end

`ifdef STDC_COLLECT_IRQ_EN
   logic irq_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         thr   <= '0;
         irq_q <= 1'b0;
      end else begin
         if (wr_acc && (reg_sel == REG_IRQ)) thr <= wb_dat_i[15:0];
         irq_q <= ((16'(level) >= thr) && (thr != '0)) || (|ovf);
      end
   end

   assign irq_o = irq_q;
`else
   assign thr   = '0;
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_stdc_event_collector.sv
// Self-checking bench for stdc_event_collector: directed steps plus random traffic against
// a queue-based reference model. IRQ checks follow STDC_COLLECT_IRQ_EN.
module tb_stdc_event_collector;

   localparam int N_CH  = 2;
   localparam int TS_W  = 27;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic                 sys_clk;
   logic                 sys_rst;
   logic [N_CH-1:0]      ev_stb, ev_pol;
   logic [N_CH*TS_W-1:0] ev_ts;
   logic [31:0]          wb_adr, wb_dat, wb_dat_o;
   logic [3:0]           wb_sel;
   logic                 wb_cyc, wb_stb, wb_we, wb_ack_o, irq_o;

   stdc_event_collector #(.N_CH(N_CH), .TS_W(TS_W), .AW(AW)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .ev_stb_i (ev_stb),
      .ev_pol_i (ev_pol),
      .ev_ts_i  (ev_ts),
      .wb_adr_i (wb_adr),
      .wb_dat_i (wb_dat),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel),
      .wb_cyc_i (wb_cyc),
      .wb_stb_i (wb_stb),
      .wb_we_i  (wb_we),
      .wb_ack_o (wb_ack_o),
      .irq_o    (irq_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   // Reference model: events as whole words in a queue, holds as valid/word pairs.
   logic [31:0]     m_q[$];
   logic [N_CH-1:0] m_hold_v;
   logic [31:0]     m_hold_w [N_CH];
   int              m_rr;
   logic [15:0]     m_ovf;
   logic [N_CH-1:0] m_en;
   logic [15:0]     m_thr;
   logic            m_irq, m_ack;
   logic [31:0]     m_dat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold_v = '0;
      for (int k = 0; k < N_CH; k++) m_hold_w[k] = '0;
      m_rr = 0; m_ovf = '0; m_en = '0; m_thr = '0;
      m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
   endtask

   // Advance the model by one clock from the current inputs, then clock the DUT and compare.
   task automatic tick();
      logic            acc, flush, pop, push, nirq;
      logic [1:0]      a;
      logic [N_CH-1:0] old_v, old_en;
      logic [31:0]     rdv;
      int              g;
      a     = wb_adr[3:2];
      acc   = wb_cyc && wb_stb && !m_ack;
      flush = acc && wb_we && (a == 2'd2) && wb_dat[16];
      pop   = acc && !wb_we && (a == 2'd0) && (m_q.size() > 0);
      g = -1;
      for (int i = 0; i < N_CH; i++)
         if (g < 0 && m_hold_v[(m_rr + i) % N_CH]) g = (m_rr + i) % N_CH;
      push = !flush && (g >= 0) && ((m_q.size() < DEPTH) || pop);
      case (a)
         2'd0:    rdv = (m_q.size() > 0) ? m_q[0] : 32'hFFFF_FFFF;
         2'd1:    rdv = {m_ovf, 16'(m_q.size())};
         2'd2:    rdv = {16'h0, 16'(m_en)};
`ifdef STDC_COLLECT_IRQ_EN
         default: rdv = {m_irq, 15'h0, m_thr};
`else
         default: rdv = 32'h0;
`endif
      endcase
`ifdef STDC_COLLECT_IRQ_EN
      nirq = ((m_q.size() >= int'(m_thr)) && (m_thr != 0)) || (m_ovf != 0);
`else
      nirq = 1'b0;
`endif
      old_v  = m_hold_v;
      old_en = m_en;
      if (acc) m_dat = rdv;
      m_ack = acc;
      m_irq = nirq;
      if (acc && wb_we && a == 2'd1) m_ovf = m_ovf & ~wb_dat[31:16];
      if (acc && wb_we && a == 2'd2) m_en = wb_dat[N_CH-1:0];
`ifdef STDC_COLLECT_IRQ_EN
      if (acc && wb_we && a == 2'd3) m_thr = wb_dat[15:0];
`endif
      if (flush) begin
         m_q.delete();
         m_hold_v = '0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(m_hold_w[g]);
            m_hold_v[g] = 1'b0;
            m_rr = (g + 1) % N_CH;
         end
         for (int k = 0; k < N_CH; k++) begin
            if (ev_stb[k] && old_en[k]) begin
               if (!old_v[k] || (push && g == k)) begin
                  m_hold_v[k] = 1'b1;
                  m_hold_w[k] = {4'(k), ev_pol[k], ev_ts[k*TS_W +: TS_W]};
               end else begin
                  m_ovf[k] = 1'b1;
               end
            end
         end
      end
      @(posedge sys_clk);
      #1;
      chk("ack", {31'h0, wb_ack_o}, {31'h0, m_ack});
      chk("irq", {31'h0, irq_o}, {31'h0, m_irq});
   endtask

   task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_adr = {28'h0, a, 2'b00}; wb_dat = d;
      tick();
      rd = wb_dat_o;
      if (!we) chk("rd_data", wb_dat_o, m_dat);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      tick();
   endtask

   task automatic strobe(input logic [N_CH-1:0] s, input logic [N_CH-1:0] p,
                         input logic [26:0] ts0, input logic [26:0] ts1);
      ev_stb = s; ev_pol = p; ev_ts = {ts1, ts0};
      tick();
      ev_stb = '0;
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      int          op;
      sys_rst = 1'b0;
      ev_stb = '0; ev_pol = '0; ev_ts = '0;
      wb_adr = '0; wb_dat = '0; wb_sel = 4'hF;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      model_reset();
      #1 sys_rst = 1'b1;
      #2;
      chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      #20 sys_rst = 1'b0;

      // Single event through hold and FIFO.
      bus(1'b1, 2'd2, 32'h3, rd);
      strobe(2'b01, 2'b01, 27'h123, 27'h0);
      tick();
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t1_level1", rd & 32'h7F, 32'h1);
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t1_word", rd, 32'h0800_0123);
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t1_level0", rd & 32'h7F, 32'h0);

      // Move the pointer back to ch0, then a simultaneous pair.
      strobe(2'b10, 2'b00, 27'h0, 27'h55);
      tick();
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t2_ch1_only", rd, 32'h1000_0055);
      strobe(2'b11, 2'b10, 27'hAA, 27'hBB);
      tick();
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t2_first_ch0", rd, 32'h0000_00AA);
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t2_second_ch1", rd, 32'h1800_00BB);

      // Fill to capacity, occupy both holds, lose one more on ch0.
      for (int i = 0; i < DEPTH; i++) begin
         strobe(2'b01, N_CH'(i & 1), 27'(i), 27'h0);
         tick();
      end
      strobe(2'b11, 2'b00, 27'h1000, 27'h2000);
      tick();
      strobe(2'b01, 2'b00, 27'h3000, 27'h0);
      tick();
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t3_full_ovf", rd & 32'h0003_007F, 32'h0001_0040);
      n = 0;
      for (int i = 0; i < 80; i++) begin
         bus(1'b0, 2'd0, 32'h0, rd);
         if (rd == 32'hFFFF_FFFF) break;
         n++;
      end
      chk("t3_drained", 32'(n), 32'd66);

      // Empty read and overflow clear.
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t4_empty", rd, 32'hFFFF_FFFF);
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t4_level0", rd & 32'h7F, 32'h0);
      bus(1'b1, 2'd1, 32'h0001_0000, rd);
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t4_ovf_clr", rd & 32'h0001_0000, 32'h0);

      // Threshold interrupt.
      bus(1'b1, 2'd3, 32'h4, rd);
`ifdef STDC_COLLECT_IRQ_EN
      for (int i = 0; i < 3; i++) begin
         strobe(2'b01, 2'b01, 27'(i + 16), 27'h0);
         tick();
      end
      tick();
      chk("t5_irq_lo", {31'h0, irq_o}, 32'h0);
      strobe(2'b01, 2'b01, 27'h77, 27'h0);
      tick();
      tick();
      chk("t5_irq_hi", {31'h0, irq_o}, 32'h1);
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("t5_irq_pop", {31'h0, irq_o}, 32'h0);
      bus(1'b1, 2'd3, 32'h0, rd);
      for (int i = 0; i < 3; i++) bus(1'b0, 2'd0, 32'h0, rd);
`else
      bus(1'b0, 2'd3, 32'h0, rd);
      chk("t5_irq_reg0", rd, 32'h0);
      chk("t5_irq_tied", {31'h0, irq_o}, 32'h0);
`endif

      // Random traffic, flushes and clears against the model.
      for (int it = 0; it < 400; it++) begin
         ev_stb = N_CH'($urandom_range(0, 3));
         ev_pol = N_CH'($urandom);
         ev_ts  = {27'($urandom), 27'($urandom)};
         op = $urandom_range(0, 11);
         if (op < 6)       tick();
         else if (op < 9)  bus(1'b0, 2'd0, 32'h0, rd);
         else if (op == 9) bus(1'b0, 2'd1, 32'h0, rd);
         else if (op == 10)
            bus(1'b1, 2'd2, {15'h0, 1'($urandom_range(0, 3) == 0), 14'h0, 2'($urandom_range(1, 3))}, rd);
         else
            bus(1'b1, 2'd1, {14'h0, 2'($urandom), 16'h0}, rd);
      end
      ev_stb = '0;
      bus(1'b0, 2'd1, 32'h0, rd);

      // Asynchronous reset in the middle of an access with strobes pending.
      bus(1'b1, 2'd2, 32'h3, rd);
      bus(1'b1, 2'd3, 32'h1, rd);
      strobe(2'b11, 2'b11, 27'h9, 27'hA);
      tick();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0;
      ev_stb = 2'b11;
      tick();
      #3 sys_rst = 1'b1;
      #1;
      chk("t6_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("t6_irq", {31'h0, irq_o}, 32'h0);
      chk("t6_dat", wb_dat_o, 32'h0);
      model_reset();
      wb_cyc = 1'b0; wb_stb = 1'b0; ev_stb = '0;
      #7 sys_rst = 1'b0;
      bus(1'b0, 2'd1, 32'h0, rd);
      chk("t6_stat", rd, 32'h0);
      bus(1'b0, 2'd2, 32'h0, rd);
      chk("t6_mask", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
